// File: rtl/cmp_fwd_pkg.sv
// Shared types and constants for the ID-stage compare forwarding scoreboard.
package cmp_fwd_pkg;

  localparam int unsigned RD_MAX_W  = 16;
  localparam int unsigned LAT_MAX_W = 8;

  localparam int unsigned LAT_ALU  = 2;
  localparam int unsigned LAT_LOAD = 3;

  // One in-flight instruction; fields sized for the widest supported AW/LW.
  typedef struct packed {
    logic                 valid;
    logic [RD_MAX_W-1:0]  rd;
    logic                 regwren;
    logic [LAT_MAX_W-1:0] lat;
  } slot_t;

  function automatic int unsigned lw_for_depth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cmp_fwd_src_sel.sv
// Priority match of one compare source against the in-flight slots.
module cmp_fwd_src_sel
  import cmp_fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned LW    = lw_for_depth(DEPTH)
) (
  input  logic [AW-1:0]     rs_i,
  input  slot_t [DEPTH:1]   slots_i,
  output logic [LW-1:0]     sel_c,
  output logic              ready_c
);

  logic [LAT_MAX_W-1:0] lat_eff;

  // Scan oldest to youngest so the youngest matching writer is left standing.
  always_comb begin
    sel_c   = '0;
    ready_c = 1'b1;
    lat_eff = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (slots_i[k].valid && slots_i[k].regwren && (slots_i[k].rd != '0) &&
          (slots_i[k].rd == RD_MAX_W'(rs_i))) begin
        lat_eff = (slots_i[k].lat == '0) ? LAT_MAX_W'(1) : slots_i[k].lat;
        ready_c = (k >= int'(lat_eff));
        sel_c   = ready_c ? LW'(k) : '0;
      end
    end
  end

endmodule

// File: rtl/cmp_fwd_scoreboard.sv
// Decode-stage forwarding/hazard unit for early branch compare: slot shift
// register of in-flight writers, per-source forward select, stall and counter.
module cmp_fwd_scoreboard
  import cmp_fwd_pkg::*;
#(
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned LW    = lw_for_depth(DEPTH),
  parameter int unsigned SCW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_rs,
  input  logic [NSRC-1:0]    id_rs_used,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_regwren,
  input  logic [LW-1:0]      id_lat,
  output logic [NSRC*LW-1:0] frw_sel,
  output logic               stall,
  output logic [SCW-1:0]     stall_cnt,
  input  logic               stall_cnt_clr
);

  slot_t [DEPTH:1] slots_q, slots_d;
  logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0] ready_c;
  logic            stall_c;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    cmp_fwd_src_sel #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .LW    (LW)
    ) u_sel (
      .rs_i    (id_rs[i*AW +: AW]),
      .slots_i (slots_q),
      .sel_c   (frw_sel[i*LW +: LW]),
      .ready_c (ready_c[i])
    );
  end

  // Flush squashes the ID instruction, so it never waits on a producer.
  always_comb begin
    stall_c = id_valid && !flush && |(id_rs_used & ~ready_c);
  end

  assign stall     = stall_c;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    slots_d = slots_q;
    if (advance) begin
      for (int k = int'(DEPTH); k >= 2; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[1] = '0;
      if (id_valid && !stall_c && !flush) begin
        slots_d[1].valid   = 1'b1;
        slots_d[1].rd      = RD_MAX_W'(id_rd);
        slots_d[1].regwren = id_regwren;
        slots_d[1].lat     = LAT_MAX_W'(id_lat);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_c && advance && (stall_cnt_q != {SCW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_cmp_fwd_scoreboard.sv
// Directed and random checks of cmp_fwd_scoreboard against an age-ordered
// pipeline model of in-flight instructions.
module tb_cmp_fwd_scoreboard;
  import cmp_fwd_pkg::*;

  localparam int unsigned NSRC  = 2;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned AW    = 5;
  localparam int unsigned LW    = 2;
  localparam int unsigned SCW   = 6;
  localparam int CNT_MAX = (1 << SCW) - 1;

  logic               clk;
  logic               rst_n;
  logic               advance;
  logic               flush;
  logic               id_valid;
  logic [NSRC*AW-1:0] id_rs;
  logic [NSRC-1:0]    id_rs_used;
  logic [AW-1:0]      id_rd;
  logic               id_regwren;
  logic [LW-1:0]      id_lat;
  logic [NSRC*LW-1:0] frw_sel;
  logic               stall;
  logic [SCW-1:0]     stall_cnt;
  logic               stall_cnt_clr;

  cmp_fwd_scoreboard #(
    .NSRC (NSRC), .DEPTH (DEPTH), .AW (AW), .LW (LW), .SCW (SCW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (advance),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rs_used    (id_rs_used),
    .id_rd         (id_rd),
    .id_regwren    (id_regwren),
    .id_lat        (id_lat),
    .frw_sel       (frw_sel),
    .stall         (stall),
    .stall_cnt     (stall_cnt),
    .stall_cnt_clr (stall_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Model: pipe age 1 = just left ID; index = age in stages.
  bit m_v   [1:DEPTH];
  int m_rd  [1:DEPTH];
  bit m_wr  [1:DEPTH];
  int m_lat [1:DEPTH];
  int m_cnt;

  int obs_stall, obs_f0, obs_f1, obs_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      m_v[k] = 0; m_rd[k] = 0; m_wr[k] = 0; m_lat[k] = 0;
    end
    m_cnt = 0;
  endtask

  // Youngest in-flight writer of rs decides; ready once its age reaches its latency.
  task automatic model_src(input int rs, output int sel, output bit rdy);
    bit found;
    found = 0;
    sel = 0;
    rdy = 1;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && m_v[k] && m_wr[k] && m_rd[k] != 0 && m_rd[k] == rs) begin
        found = 1;
        rdy = (k >= ((m_lat[k] == 0) ? 1 : m_lat[k]));
        sel = rdy ? k : 0;
      end
    end
  endtask

  task automatic step(input bit adv, input bit fl, input bit vld,
                      input int rs0, input int rs1, input bit [1:0] used,
                      input int rd, input bit wr, input int lat,
                      input bit clr, input string tag);
    int s0, s1;
    bit r0, r1, e_stall;
    @(negedge clk);
    advance       = adv;
    flush         = fl;
    id_valid      = vld;
    id_rs         = {AW'(rs1), AW'(rs0)};
    id_rs_used    = used;
    id_rd         = AW'(rd);
    id_regwren    = wr;
    id_lat        = LW'(lat);
    stall_cnt_clr = clr;
    #1;
    model_src(rs0, s0, r0);
    model_src(rs1, s1, r1);
    e_stall = vld && !fl && ((used[0] && !r0) || (used[1] && !r1));
    obs_stall = int'(stall);
    obs_f0    = int'(frw_sel[LW-1:0]);
    obs_f1    = int'(frw_sel[2*LW-1:LW]);
    obs_cnt   = int'(stall_cnt);
    check({tag, ":stall"}, obs_stall, int'(e_stall));
    check({tag, ":frw0"},  obs_f0, s0);
    check({tag, ":frw1"},  obs_f1, s1);
    check({tag, ":cnt"},   obs_cnt, m_cnt);
    if (clr) m_cnt = 0;
    else if (e_stall && adv && m_cnt < CNT_MAX) m_cnt++;
    if (adv) begin
      for (int k = DEPTH; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1];
        m_wr[k] = m_wr[k-1]; m_lat[k] = m_lat[k-1];
      end
      m_v[1] = vld && !e_stall && !fl;
      m_rd[1] = rd; m_wr[1] = wr; m_lat[1] = lat;
    end
  endtask

  task automatic bubbles(input int n);
    for (int j = 0; j < n; j++) step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, "bub");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst_n = 1'b0;
    advance = 0; flush = 0; id_valid = 0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_regwren = 0; id_lat = '0; stall_cnt_clr = 0;
    #12;
    check("rst:stall", int'(stall), 0);
    check("rst:frw", int'(frw_sel), 0);
    check("rst:cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU producer rd=5 then dependent branch
    step(1, 0, 1, 0, 0, 2'b00, 5, 1, LAT_ALU, 1, "alu_prod");
    step(1, 0, 1, 5, 0, 2'b01, 0, 0, 0, 0, "alu_br1");
    check("tp_alu:stall1", obs_stall, 1);
    check("tp_alu:frw0_1", obs_f0, 0);
    step(1, 0, 1, 5, 0, 2'b01, 0, 0, 0, 0, "alu_br2");
    check("tp_alu:stall2", obs_stall, 0);
    check("tp_alu:frw0_2", obs_f0, 2);
    check("tp_alu:cnt", obs_cnt, 1);
    bubbles(3);

    // Load rd=7 then branch rs1=0, rs2=7
    step(1, 0, 1, 0, 0, 2'b00, 7, 1, LAT_LOAD, 0, "ld_prod");
    step(1, 0, 1, 0, 7, 2'b11, 0, 0, 0, 0, "ld_br1");
    check("tp_ld:stall1", obs_stall, 1);
    step(1, 0, 1, 0, 7, 2'b11, 0, 0, 0, 0, "ld_br2");
    check("tp_ld:stall2", obs_stall, 1);
    step(1, 0, 1, 0, 7, 2'b11, 0, 0, 0, 0, "ld_br3");
    check("tp_ld:stall3", obs_stall, 0);
    check("tp_ld:frw1", obs_f1, 3);
    check("tp_ld:frw0", obs_f0, 0);
    bubbles(3);

    // Writes to x0 and a non-writing rd=9
    step(1, 0, 1, 0, 0, 2'b00, 0, 1, LAT_ALU, 0, "x0_prod");
    step(1, 0, 1, 0, 0, 2'b00, 9, 0, LAT_ALU, 0, "nowr_prod");
    step(1, 0, 1, 0, 9, 2'b11, 0, 0, 0, 0, "x0_br");
    check("tp_x0:stall", obs_stall, 0);
    check("tp_x0:frw", obs_f0 + obs_f1, 0);
    bubbles(3);

    // Two producers of rd=4: youngest ready in slot 2
    step(1, 0, 1, 0, 0, 2'b00, 4, 1, LAT_ALU, 0, "dup_p1");
    step(1, 0, 1, 0, 0, 2'b00, 4, 1, LAT_ALU, 0, "dup_p2");
    step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, "dup_bub");
    step(1, 0, 1, 4, 0, 2'b01, 0, 0, 0, 0, "dup_br");
    check("tp_dup:frw0", obs_f0, 2);
    check("tp_dup:stall", obs_stall, 0);
    bubbles(3);
    // Youngest not ready in slot 1, older ready copy in slot 3
    step(1, 0, 1, 0, 0, 2'b00, 4, 1, LAT_ALU, 0, "stale_p1");
    step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, "stale_bub");
    step(1, 0, 1, 0, 0, 2'b00, 4, 1, LAT_ALU, 0, "stale_p2");
    step(1, 0, 1, 4, 0, 2'b01, 0, 0, 0, 0, "stale_br");
    check("tp_stale:stall", obs_stall, 1);
    check("tp_stale:frw0", obs_f0, 0);
    bubbles(3);

    // Flush together with a would-be stall
    step(1, 0, 1, 0, 0, 2'b00, 6, 1, LAT_ALU, 1, "fl_prod");
    step(1, 1, 1, 6, 0, 2'b01, 0, 0, 0, 0, "fl_br");
    check("tp_fl:stall", obs_stall, 0);
    step(1, 0, 1, 6, 0, 2'b01, 0, 0, 0, 0, "fl_after");
    check("tp_fl:frw0", obs_f0, 2);
    check("tp_fl:cnt", obs_cnt, 0);
    bubbles(3);

    // advance low: frozen slots and counter
    step(1, 0, 1, 0, 0, 2'b00, 8, 1, LAT_ALU, 1, "hold_prod");
    for (int j = 0; j < 3; j++) step(0, 0, 1, 8, 0, 2'b01, 0, 0, 0, 0, "hold_br");
    check("tp_hold:stall", obs_stall, 1);
    check("tp_hold:cnt", obs_cnt, 0);
    step(1, 0, 1, 8, 0, 2'b01, 0, 0, 0, 0, "hold_go");
    step(1, 0, 1, 8, 0, 2'b01, 0, 0, 0, 0, "hold_fwd");
    check("tp_hold:frw0", obs_f0, 2);
    check("tp_hold:cnt1", obs_cnt, 1);
    bubbles(3);

    // Saturation: repeated load-use gives two stalls per load
    step(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, "sat_clr");
    for (int j = 0; j < 40; j++) begin
      step(1, 0, 1, 0, 0, 2'b00, 10, 1, LAT_LOAD, 0, "sat_ld");
      step(1, 0, 1, 10, 0, 2'b01, 0, 0, 0, 0, "sat_br1");
      step(1, 0, 1, 10, 0, 2'b01, 0, 0, 0, 0, "sat_br2");
    end
    step(1, 0, 1, 0, 0, 2'b00, 10, 1, LAT_LOAD, 0, "sat_end");
    check("tp_sat:cnt", obs_cnt, CNT_MAX);
    step(1, 0, 1, 10, 0, 2'b01, 0, 0, 0, 1, "sat_clrst");
    step(1, 0, 1, 10, 0, 2'b01, 0, 0, 0, 0, "sat_after");
    check("tp_sat:cleared", obs_cnt, 0);
    check("tp_sat:stall", obs_stall, 1);

    // Reset mid-stall clears everything at once
    @(negedge clk);
    #1;
    check("rstmid:pre_cnt", int'(stall_cnt), m_cnt);
    rst_n = 1'b0;
    #1;
    check("rstmid:stall", int'(stall), 0);
    check("rstmid:frw", int'(frw_sel), 0);
    check("rstmid:cnt", int'(stall_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 10, 3, 2'b11, 0, 0, 0, 0, "post_rst");
    check("post_rst:frw", obs_f0 + obs_f1, 0);

    // Random traffic on a small register range to force hazards
    for (int j = 0; j < 400; j++) begin
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 8),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 49) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
